water_grid_controller: RTL and testbench
========================================

Name: water_grid_controller

Overview:
- Multi-zone successor to the single city/town reservoir controller. One shared reservoir feeds N_ZONES population zones.
- Each zone has a saturating population counter. Demand per zone is population × per-capita rate, with a fixed fraction returned as treated sewage.
- A 4-state hysteretic supply-mode FSM (NORMAL/CONSERVE/RATION/DROUGHT) throttles or sheds zones as the level drops.
- Sits at the top of the water-management datapath and drives status outputs to the display/alarm logic.

Parameters:
- N_ZONES, 4, number of consumer zones.
- POP_W, 8, population counter width per zone.
- RATE_W, 4, per-zone population step width.
- COLLECT_W, 6, rain collection rate width.
- LEVEL_W, 11, reservoir level width.
- MAX_LEVEL, 1500, reservoir capacity; level clamps here.
- INIT_LEVEL, 750, level after reset.
- INIT_POP, 20, every zone's population after reset.
- DEMAND_PER_CAPITA, 2, demand units per person per cycle.
- RECYCLE_NUM, 9, treated return = floor(served_demand × RECYCLE_NUM / 16).
- LOW_TH, 600, NORMAL→CONSERVE threshold.
- CRIT_TH, 300, CONSERVE→RATION threshold.
- DROUGHT_TH, 100, RATION→DROUGHT threshold.
- HYST, 50, hysteresis added to each threshold on the way back up.
- PRIORITY_ZONES, 2, zones 0..PRIORITY_ZONES-1 are still served in RATION.

Ports:
- clk, input, 1, system clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- zone_add, input, N_ZONES, per-zone population increment request.
- zone_sub, input, N_ZONES, per-zone population decrement request.
- zone_rate, input, N_ZONES×RATE_W, packed per-zone step; zone i occupies bits [i×RATE_W +: RATE_W].
- rain_add, input, 1, rain inflow enable this cycle.
- water_collection_rate, input, COLLECT_W, inflow = 2 × rate when rain_add.
- zone_population, output, N_ZONES×POP_W, packed registered populations.
- zone_served, output, N_ZONES, registered: zones supplied on the last update.
- reservoir_level, output, LEVEL_W, registered level.
- supply_mode, output, 2, encoding 0 NORMAL, 1 CONSERVE, 2 RATION, 3 DROUGHT.
- overflow, output, 1, registered; 1 for the cycle after a clamp to MAX_LEVEL.
- underflow, output, 1, registered; 1 for the cycle after a supply refusal.
- spill_count, output, 16, saturating count of clamp events.

Behaviour:
- Reset (reset_n low, asynchronous): populations=INIT_POP; level=INIT_LEVEL; supply_mode=NORMAL; zone_served=0; overflow=0; underflow=0; spill_count=0. Release is synchronous to the next clk edge.
- Population update, per zone, per edge:
  - add has priority over sub.
  - pop+rate saturates at 2^POP_W-1.
  - pop-rate saturates at 0.
  - No request: hold.
  - Zones update independently.
- Demand uses the registered (pre-edge) populations: d_i = pop_i × DEMAND_PER_CAPITA.
- Eligibility by the current registered mode:
  - NORMAL: all zones, full demand.
  - CONSERVE: all zones, demand d_i>>1.
  - RATION: zones < PRIORITY_ZONES only, full demand.
  - DROUGHT: none.
- served_total = sum of eligible demands, computed at width LEVEL_W+POP_W.
- Supply decision: if level ≥ served_total, supply the eligible zones and set zone_served to the eligible mask. Otherwise supply nothing, set zone_served=0 and underflow=1. Partial service is never performed.
- recycle = (supplied_total × RECYCLE_NUM)>>4.
- inflow = rain_add ? 2 × water_collection_rate : 0. Rain is ignored when level ≥ MAX_LEVEL.
- Level update: next = level − supplied_total + recycle + inflow, computed unsigned at LEVEL_W+POP_W+1 bits.
  - If next > MAX_LEVEL: clamp to MAX_LEVEL, overflow=1, spill_count+1 (saturating at 0xFFFF).
- Mode FSM:
  - Transitions are evaluated on the registered level before the edge. At most one step per edge. Single-cycle latency: a level crossing is first seen in supply_mode one edge later, and that edge's update still uses the old mode.
  - NORMAL→CONSERVE: level < LOW_TH.
  - CONSERVE→NORMAL: level ≥ LOW_TH+HYST.
  - CONSERVE→RATION: level < CRIT_TH.
  - RATION→CONSERVE: level ≥ CRIT_TH+HYST.
  - RATION→DROUGHT: level < DROUGHT_TH.
  - DROUGHT→RATION: level ≥ DROUGHT_TH+HYST.
  - Downward checks take priority where both could apply.
- Reset asserted mid-operation forces all reset values immediately, regardless of the clock.

Decomposition:
- Package water_grid_pkg holds:
  - supply_mode_t enum (NORMAL/CONSERVE/RATION/DROUGHT, 2-bit).
  - RECYCLE_SHIFT=4.
  - Default threshold constants.
- Sub-module zone_population_counter (one instance per zone via generate) holds one zone's saturating counter, its reset to INIT_POP, and its add/sub priority.
- Reservoir arithmetic and the FSM stay in the top module.

Test Plan:
- Reset then idle, defaults → level 680, 610, 540 on the first three edges. supply_mode becomes CONSERVE at edge 4, where the level goes to 470. Edge 5 uses CONSERVE (served 80, recycle 45) → 435.
- Zone 0 at pop 250, zone_add[0]=1, rate 15 → 255 and holds. Zone 1 at pop 5, zone_sub[1]=1, rate 15 → 0. zone_add and zone_sub both high → add wins.
- Level 1480, NORMAL, all pops 20, rain_add with rate 63 → raw 1536, clamps to 1500. overflow=1 on the next cycle and spill_count increments by 1.
- RATION, level 40, pops 20 → served_total 80 > 40. zone_served=0, underflow=1, level changes only by inflow.
- In CONSERVE, drive the level up: at 620 the mode stays CONSERVE; at ≥650 it returns to NORMAL on the next edge. Then the level dips to 599 → CONSERVE again.
- Assert reset_n low asynchronously mid-run at spill_count 3, mode RATION → all outputs take reset values before the next clk edge.

Source files
------------

// File: rtl/water_grid_pkg.sv
// Shared types and default constants for the multi-zone water grid controller.
package water_grid_pkg;

  // Supply mode, ordered from most to least generous.
  typedef enum logic [1:0] {
    MODE_NORMAL   = 2'd0,
    MODE_CONSERVE = 2'd1,
    MODE_RATION   = 2'd2,
    MODE_DROUGHT  = 2'd3
  } supply_mode_t;

  // Treated return is served_demand * RECYCLE_NUM / 2^RECYCLE_SHIFT.
  localparam int RECYCLE_SHIFT = 4;

  // Default mode thresholds (reservoir level units).
  localparam int DEF_LOW_TH     = 600;
  localparam int DEF_CRIT_TH    = 300;
  localparam int DEF_DROUGHT_TH = 100;
  localparam int DEF_HYST       = 50;

endpackage

// File: rtl/water_grid_controller_zone.sv
// One zone's saturating population counter. Add beats sub; both saturate.
module zone_population_counter
  import water_grid_pkg::*;
#(
  parameter int POP_W    = 8,
  parameter int RATE_W   = 4,
  parameter int INIT_POP = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              add,
  input  logic              sub,
  input  logic [RATE_W-1:0] rate,
  output logic [POP_W-1:0]  pop
);

  localparam int EXT_W = POP_W + 1;

  logic [POP_W-1:0] pop_q;
  logic [POP_W-1:0] pop_d;
  logic [EXT_W-1:0] sum_ext;
  logic [POP_W-1:0] rate_ext;

  // Next population: saturating increment, else saturating decrement, else hold.
  always_comb begin
    pop_d    = pop_q;
    rate_ext = POP_W'(rate);
    sum_ext  = {1'b0, pop_q} + {1'b0, rate_ext};
    if (add) begin
      pop_d = sum_ext[POP_W] ? {POP_W{1'b1}} : sum_ext[POP_W-1:0];
    end else if (sub) begin
      pop_d = (pop_q < rate_ext) ? '0 : (pop_q - rate_ext);
    end
  end

  // Population register, asynchronously reset to the starting population.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pop_q <= POP_W'(INIT_POP);
    end else begin
      pop_q <= pop_d;
    end
  end

  assign pop = pop_q;

endmodule

// File: rtl/water_grid_controller.sv
// Shared-reservoir controller: per-zone demand, all-or-nothing supply,
// recycle/rain/clamp level arithmetic and a hysteretic supply-mode FSM.
module water_grid_controller
  import water_grid_pkg::*;
#(
  parameter int N_ZONES           = 4,
  parameter int POP_W             = 8,
  parameter int RATE_W            = 4,
  parameter int COLLECT_W         = 6,
  parameter int LEVEL_W           = 11,
  parameter int MAX_LEVEL         = 1500,
  parameter int INIT_LEVEL        = 750,
  parameter int INIT_POP          = 20,
  parameter int DEMAND_PER_CAPITA = 2,
  parameter int RECYCLE_NUM       = 9,
  parameter int LOW_TH            = DEF_LOW_TH,
  parameter int CRIT_TH           = DEF_CRIT_TH,
  parameter int DROUGHT_TH        = DEF_DROUGHT_TH,
  parameter int HYST              = DEF_HYST,
  parameter int PRIORITY_ZONES    = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_ZONES-1:0]          zone_add,
  input  logic [N_ZONES-1:0]          zone_sub,
  input  logic [N_ZONES*RATE_W-1:0]   zone_rate,
  input  logic                        rain_add,
  input  logic [COLLECT_W-1:0]        water_collection_rate,
  output logic [N_ZONES*POP_W-1:0]    zone_population,
  output logic [N_ZONES-1:0]          zone_served,
  output logic [LEVEL_W-1:0]          reservoir_level,
  output logic [1:0]                  supply_mode,
  output logic                        overflow,
  output logic                        underflow,
  output logic [15:0]                 spill_count
);

  // Demand sums fit in LEVEL_W+POP_W; the level update needs one more bit
  // so that level + recycle + inflow never wraps before the clamp.
  localparam int SUM_W  = LEVEL_W + POP_W;
  localparam int NEXT_W = SUM_W + 1;
  localparam int PROD_W = NEXT_W + RECYCLE_SHIFT;

  localparam logic [LEVEL_W-1:0] MAX_LEVEL_L  = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] INIT_LEVEL_L = LEVEL_W'(INIT_LEVEL);
  localparam logic [LEVEL_W-1:0] LOW_DN       = LEVEL_W'(LOW_TH);
  localparam logic [LEVEL_W-1:0] LOW_UP       = LEVEL_W'(LOW_TH + HYST);
  localparam logic [LEVEL_W-1:0] CRIT_DN      = LEVEL_W'(CRIT_TH);
  localparam logic [LEVEL_W-1:0] CRIT_UP      = LEVEL_W'(CRIT_TH + HYST);
  localparam logic [LEVEL_W-1:0] DROUGHT_DN   = LEVEL_W'(DROUGHT_TH);
  localparam logic [LEVEL_W-1:0] DROUGHT_UP   = LEVEL_W'(DROUGHT_TH + HYST);

  // Registered state
  supply_mode_t         mode_q,      mode_d;
  logic [LEVEL_W-1:0]   level_q,     level_d;
  logic [N_ZONES-1:0]   served_q,    served_d;
  logic                 overflow_q,  overflow_d;
  logic                 underflow_q, underflow_d;
  logic [15:0]          spill_q,     spill_d;

  // Per-zone demand and eligibility under the current (registered) mode
  logic [N_ZONES-1:0]   eligible;
  logic [SUM_W-1:0]     eff_demand [N_ZONES];

  // Reservoir arithmetic
  logic [SUM_W-1:0]     served_total;
  logic                 supply_ok;
  logic [SUM_W-1:0]     supplied_total;
  logic [PROD_W-1:0]    recycle_prod;
  logic [NEXT_W-1:0]    recycle;
  logic [NEXT_W-1:0]    inflow;
  logic [NEXT_W-1:0]    level_sum;
  logic                 clamp;

  for (genvar gi = 0; gi < N_ZONES; gi++) begin : g_zone
    localparam bit IS_PRIORITY = (gi < PRIORITY_ZONES);
    logic [SUM_W-1:0] full_demand;

    zone_population_counter #(
      .POP_W    (POP_W),
      .RATE_W   (RATE_W),
      .INIT_POP (INIT_POP)
    ) u_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .add     (zone_add[gi]),
      .sub     (zone_sub[gi]),
      .rate    (zone_rate[gi*RATE_W +: RATE_W]),
      .pop     (zone_population[gi*POP_W +: POP_W])
    );

    // Demand is taken from the pre-edge population, so this edge's add/sub
    // only affects the next update.
    assign full_demand    = SUM_W'(zone_population[gi*POP_W +: POP_W]) *
                            SUM_W'(DEMAND_PER_CAPITA);
    assign eff_demand[gi] = (mode_q == MODE_CONSERVE) ? (full_demand >> 1) : full_demand;
    assign eligible[gi]   = (mode_q == MODE_NORMAL) || (mode_q == MODE_CONSERVE) ||
                            ((mode_q == MODE_RATION) && IS_PRIORITY);
  end

  // Total eligible demand and the all-or-nothing supply decision.
  always_comb begin
    served_total = '0;
    for (int i = 0; i < N_ZONES; i++) begin
      if (eligible[i]) begin
        served_total = served_total + eff_demand[i];
      end
    end
    supply_ok      = (SUM_W'(level_q) >= served_total);
    supplied_total = supply_ok ? served_total : '0;
  end

  // Level update: draw, treated return, rain (ignored when already full), clamp.
  always_comb begin
    recycle_prod = PROD_W'(supplied_total) * PROD_W'(RECYCLE_NUM);
    recycle      = NEXT_W'(recycle_prod >> RECYCLE_SHIFT);
    inflow       = '0;
    if (rain_add && (level_q < MAX_LEVEL_L)) begin
      inflow = NEXT_W'({water_collection_rate, 1'b0});
    end
    level_sum   = NEXT_W'(level_q) - NEXT_W'(supplied_total) + recycle + inflow;
    clamp       = (level_sum > NEXT_W'(MAX_LEVEL));
    level_d     = clamp ? MAX_LEVEL_L : LEVEL_W'(level_sum);
    overflow_d  = clamp;
    spill_d     = spill_q;
    if (clamp && (spill_q != 16'hFFFF)) begin
      spill_d = spill_q + 16'd1;
    end
    served_d    = supply_ok ? eligible : '0;
    underflow_d = ~supply_ok;
  end

  // Mode FSM next state: one step per edge from the pre-edge level; the
  // downward check is tested first so it wins.
  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      MODE_NORMAL: begin
        if (level_q < LOW_DN) mode_d = MODE_CONSERVE;
      end
      MODE_CONSERVE: begin
        if (level_q < CRIT_DN)      mode_d = MODE_RATION;
        else if (level_q >= LOW_UP) mode_d = MODE_NORMAL;
      end
      MODE_RATION: begin
        if (level_q < DROUGHT_DN)    mode_d = MODE_DROUGHT;
        else if (level_q >= CRIT_UP) mode_d = MODE_CONSERVE;
      end
      MODE_DROUGHT: begin
        if (level_q >= DROUGHT_UP) mode_d = MODE_RATION;
      end
      default: mode_d = MODE_NORMAL;
    endcase
  end

  // Reservoir, status and mode registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= MODE_NORMAL;
      level_q     <= INIT_LEVEL_L;
      served_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      spill_q     <= '0;
    end else begin
      mode_q      <= mode_d;
      level_q     <= level_d;
      served_q    <= served_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      spill_q     <= spill_d;
    end
  end

  assign zone_served     = served_q;
  assign reservoir_level = level_q;
  assign supply_mode     = mode_q;
  assign overflow        = overflow_q;
  assign underflow       = underflow_q;
  assign spill_count     = spill_q;

endmodule

// File: tb/tb_water_grid_controller.sv
// Directed + randomized bench for water_grid_controller with a behavioural
// reference model computed from the supply rules using plain integers.
module tb_water_grid_controller;

  logic        clk;
  logic        reset_n;
  logic [3:0]  zone_add;
  logic [3:0]  zone_sub;
  logic [15:0] zone_rate;
  logic        rain_add;
  logic [5:0]  water_collection_rate;
  logic [31:0] zone_population;
  logic [3:0]  zone_served;
  logic [10:0] reservoir_level;
  logic [1:0]  supply_mode;
  logic        overflow;
  logic        underflow;
  logic [15:0] spill_count;

  water_grid_controller dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .zone_add              (zone_add),
    .zone_sub              (zone_sub),
    .zone_rate             (zone_rate),
    .rain_add              (rain_add),
    .water_collection_rate (water_collection_rate),
    .zone_population       (zone_population),
    .zone_served           (zone_served),
    .reservoir_level       (reservoir_level),
    .supply_mode           (supply_mode),
    .overflow              (overflow),
    .underflow             (underflow),
    .spill_count           (spill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Stimulus for the coming edge
  bit [3:0] add_v, sub_v;
  bit [3:0] rate_v [4];
  bit       rain_v;
  bit [5:0] col_v;

  // Reference model state
  int       m_pop [4];
  int       m_level, m_mode, m_spill;
  bit       m_ovf, m_unf;
  bit [3:0] m_served;

  // Mode thresholds indexed by mode: leave-downward and leave-upward levels
  int down_th [3] = '{600, 300, 100};
  int up_th   [4] = '{0, 650, 350, 150};

  int tp_lvl  [5] = '{680, 610, 540, 470, 435};
  int tp_mode [5] = '{0, 0, 0, 1, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s pop%0d", tag, i), 32'(zone_population[i*8 +: 8]), m_pop[i]);
    chk({tag, " served"},    32'(zone_served),     32'(m_served));
    chk({tag, " level"},     32'(reservoir_level), m_level);
    chk({tag, " mode"},      32'(supply_mode),     m_mode);
    chk({tag, " overflow"},  32'(overflow),        32'(m_ovf));
    chk({tag, " underflow"}, 32'(underflow),       32'(m_unf));
    chk({tag, " spill"},     32'(spill_count),     m_spill);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pop[i] = 20;
    m_level = 750; m_mode = 0; m_spill = 0;
    m_ovf = 0; m_unf = 0; m_served = 4'b0;
  endtask

  task automatic model_step();
    int tot, sup, nxt, inflow, d;
    bit [3:0] elig;
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      elig[i] = (m_mode < 2) || (m_mode == 2 && i < 2);
      d = m_pop[i] * 2;
      if (m_mode == 1) d = d / 2;
      if (elig[i]) tot += d;
    end
    if (m_level >= tot) begin
      sup = tot; m_served = elig; m_unf = 0;
    end else begin
      sup = 0; m_served = 4'b0; m_unf = 1;
    end
    inflow = (rain_v && m_level < 1500) ? 2 * int'(col_v) : 0;
    nxt = m_level - sup + (sup * 9) / 16 + inflow;
    m_ovf = (nxt > 1500);
    if (m_ovf) begin
      nxt = 1500;
      if (m_spill < 65535) m_spill++;
    end
    if (m_mode < 3 && m_level < down_th[m_mode]) m_mode++;
    else if (m_mode > 0 && m_level >= up_th[m_mode]) m_mode--;
    m_level = nxt;
    for (int i = 0; i < 4; i++) begin
      if (add_v[i])      m_pop[i] = (m_pop[i] + int'(rate_v[i]) > 255) ? 255 : m_pop[i] + int'(rate_v[i]);
      else if (sub_v[i]) m_pop[i] = (m_pop[i] - int'(rate_v[i]) < 0) ? 0 : m_pop[i] - int'(rate_v[i]);
    end
  endtask

  task automatic drive_inputs();
    zone_add = add_v;
    zone_sub = sub_v;
    for (int i = 0; i < 4; i++) zone_rate[i*4 +: 4] = rate_v[i];
    rain_add = rain_v;
    water_collection_rate = col_v;
  endtask

  task automatic set_idle();
    add_v = 4'b0; sub_v = 4'b0; rain_v = 1'b0; col_v = 6'd0;
    for (int i = 0; i < 4; i++) rate_v[i] = 4'd0;
  endtask

  // Apply the staged inputs, clock once, advance the model and compare.
  task automatic step(input string tag);
    drive_inputs();
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic random_phase(input string tag, input int n, input int add_pct,
                              input int sub_pct, input int rain_pct);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 4; i++) begin
        add_v[i]  = ($urandom_range(0, 99) < add_pct);
        sub_v[i]  = ($urandom_range(0, 99) < sub_pct);
        rate_v[i] = 4'($urandom_range(0, 15));
      end
      rain_v = ($urandom_range(0, 99) < rain_pct);
      col_v  = 6'($urandom_range(0, 63));
      step(tag);
    end
  endtask

  initial begin
    set_idle();
    drive_inputs();
    reset_n = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;

    // Idle from reset: known level trajectory and the one-edge mode lag
    for (int k = 0; k < 5; k++) begin
      step($sformatf("idle%0d", k + 1));
      chk($sformatf("tp level edge%0d", k + 1), 32'(reservoir_level), tp_lvl[k]);
      chk($sformatf("tp mode edge%0d", k + 1),  32'(supply_mode),     tp_mode[k]);
    end

    // Population saturation: zone0 add, zone1 sub, zone2 add+sub (add wins)
    set_idle();
    add_v = 4'b0101; sub_v = 4'b0110;
    for (int i = 0; i < 4; i++) rate_v[i] = 4'd15;
    for (int k = 0; k < 20; k++) step("sat");
    chk("sat pop0 top",  32'(zone_population[7:0]),   255);
    chk("sat pop1 zero", 32'(zone_population[15:8]),  0);
    chk("sat pop2 add",  32'(zone_population[23:16]), 255);

    // Empty all zones, then rain hard to climb through the modes and clamp
    set_idle();
    sub_v = 4'b1111;
    for (int i = 0; i < 4; i++) rate_v[i] = 4'd15;
    for (int k = 0; k < 3; k++) step("drain");
    rain_v = 1'b1; col_v = 6'd63;
    for (int k = 0; k < 25; k++) step("fill");
    chk("fill level max", 32'(reservoir_level), 1500);
    chk("fill mode",      32'(supply_mode),     0);

    // Randomized mixes biased toward growth, shrinkage and drought
    random_phase("rand_mix",   200, 15, 15, 60);
    random_phase("rand_fill",  200,  5, 40, 90);
    random_phase("rand_drain", 200, 40,  5, 30);
    random_phase("rand_fill2", 100,  5, 50, 95);

    // Asynchronous reset between edges must take effect immediately
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    reset_n = 1'b1;
    random_phase("post_rst", 60, 15, 15, 50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
